// File: rtl/dcache_ctrl_pkg.sv
// Shared types and constants for the direct-mapped data cache controller.
package dcache_ctrl_pkg;
   localparam int TAG_W   = 5;
   localparam int IDX_W   = 6;
   localparam int LINE_W  = 64;
   localparam int WORD_W  = 16;
   localparam int LADDR_W = TAG_W + IDX_W;
   localparam int CADDR_W = LADDR_W + 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SNOOP   = 3'd1,
      ST_WB      = 3'd2,
      ST_FILL    = 3'd3,
      ST_INSTALL = 3'd4
   } state_t;

   function automatic logic [LINE_W-1:0] word_merge(input logic [LINE_W-1:0] line,
                                                    input logic [1:0]        sel,
                                                    input logic [WORD_W-1:0] word);
      logic [LINE_W-1:0] res;
      res = line;
      case (sel)
         2'd0:    res[15:0]  = word;
         2'd1:    res[31:16] = word;
         2'd2:    res[47:32] = word;
         default: res[63:48] = word;
      endcase
      return res;
   endfunction
endpackage

// File: rtl/dcache_ctrl_if.sv
// Bundle of CPU, cache-array, snoop and memory signals around the controller.
// master = controller side, slave = CPU/cache/memory environment side.
interface dcache_ctrl_if;
   import dcache_ctrl_pkg::*;

   logic [CADDR_W-1:0] cpu_addr;
   logic               cpu_re;
   logic               cpu_we;
   logic [WORD_W-1:0]  cpu_wdata;
   logic [WORD_W-1:0]  cpu_rdata;
   logic               stall;
   logic [LADDR_W-1:0] c_addr;
   logic [LINE_W-1:0]  c_wr_data;
   logic               c_wdirty;
   logic               c_we;
   logic               c_re;
   logic [LINE_W-1:0]  c_rd_data;
   logic [TAG_W-1:0]   c_tag;
   logic               c_hit;
   logic               c_dirty;
   logic               c_search;
   logic [LADDR_W-1:0] c_snp_addr;
   logic               c_snp_found;
   logic [LINE_W-1:0]  c_snp_data;
   logic               snp_req;
   logic [LADDR_W-1:0] snp_addr;
   logic               snp_ack;
   logic               snp_hit;
   logic [LINE_W-1:0]  snp_data;
   logic               mem_re;
   logic               mem_we;
   logic [LADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0]  mem_wdata;
   logic [LINE_W-1:0]  mem_rdata;
   logic               mem_rdy;

   modport master (
      input  cpu_addr, cpu_re, cpu_we, cpu_wdata,
      input  c_rd_data, c_tag, c_hit, c_dirty, c_snp_found, c_snp_data,
      input  snp_req, snp_addr, mem_rdata, mem_rdy,
      output cpu_rdata, stall, c_addr, c_wr_data, c_wdirty, c_we, c_re,
      output c_search, c_snp_addr, snp_ack, snp_hit, snp_data,
      output mem_re, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output cpu_addr, cpu_re, cpu_we, cpu_wdata,
      output c_rd_data, c_tag, c_hit, c_dirty, c_snp_found, c_snp_data,
      output snp_req, snp_addr, mem_rdata, mem_rdy,
      input  cpu_rdata, stall, c_addr, c_wr_data, c_wdirty, c_we, c_re,
      input  c_search, c_snp_addr, snp_ack, snp_hit, snp_data,
      input  mem_re, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/dcache_ctrl_word_mux.sv
// Combinational 4:1 word extract and single-word merge on a 64b cache line.
module dcache_word_mux
   import dcache_ctrl_pkg::*;
(
   input  logic [LINE_W-1:0] line,
   input  logic [1:0]        sel,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] word,
   output logic [LINE_W-1:0] merged
);
   always_comb begin
      word = '0;
      case (sel)
         2'd0:    word = line[15:0];
         2'd1:    word = line[31:16];
         2'd2:    word = line[47:32];
         default: word = line[63:48];
      endcase
   end

   assign merged = word_merge(line, sel, wdata);
endmodule

// File: rtl/dcache_ctrl.sv
// Sequencer for a direct-mapped 64-line data cache: hits, write-back/fill/install, snoop arbitration.
//   state      | meaning
//   ST_IDLE    | serve CPU hits combinationally, pick snoop or start a miss
//   ST_SNOOP   | snoop lookup on the cache snoop port; ack follows in IDLE
//   ST_WB      | write dirty victim line to memory
//   ST_FILL    | read requested line from memory
//   ST_INSTALL | write filled (and possibly merged) line into the cache
module dcache_ctrl
   import dcache_ctrl_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   dcache_ctrl_if.master bus
);
   state_t             state_q, state_d;
   logic [LADDR_W-1:0] line_q;
   logic [TAG_W-1:0]   vtag_q;
   logic [LINE_W-1:0]  victim_q;
   logic [LINE_W-1:0]  fill_q;
   logic [LINE_W-1:0]  snp_data_q;
   logic [1:0]         sel_q;
   logic               wr_q;
   logic [WORD_W-1:0]  wdata_q;
   logic               snp_ack_q;
   logic               snp_hit_q;

   logic               cpu_req;
   logic               snp_pend;
   logic               miss_latch;
   logic               in_install;
   logic [LINE_W-1:0]  mux_line;
   logic [1:0]         mux_sel;
   logic [WORD_W-1:0]  mux_wdata;
   logic [WORD_W-1:0]  mux_word;
   logic [LINE_W-1:0]  mux_merged;

   assign cpu_req    = bus.cpu_re | bus.cpu_we;
   // The requester still holds snp_req during the ack cycle; do not re-enter SNOOP on it.
   assign snp_pend   = bus.snp_req & ~snp_ack_q;
   assign in_install = (state_q == ST_INSTALL);

   assign mux_line  = in_install ? fill_q  : bus.c_rd_data;
   assign mux_sel   = in_install ? sel_q   : bus.cpu_addr[1:0];
   assign mux_wdata = in_install ? wdata_q : bus.cpu_wdata;

   dcache_word_mux u_word_mux (
      .line   (mux_line),
      .sel    (mux_sel),
      .wdata  (mux_wdata),
      .word   (mux_word),
      .merged (mux_merged)
   );

   assign bus.cpu_rdata  = mux_word;
   assign bus.c_snp_addr = bus.snp_addr;
   assign bus.snp_ack    = snp_ack_q;
   assign bus.snp_hit    = snp_hit_q;
   assign bus.snp_data   = snp_data_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         line_q     <= '0;
         vtag_q     <= '0;
         victim_q   <= '0;
         fill_q     <= '0;
         snp_data_q <= '0;
         sel_q      <= '0;
         wr_q       <= 1'b0;
         wdata_q    <= '0;
         snp_ack_q  <= 1'b0;
         snp_hit_q  <= 1'b0;
      end else begin
         snp_ack_q <= (state_q == ST_SNOOP);
         if (state_q == ST_SNOOP) begin
            snp_hit_q  <= bus.c_snp_found;
            snp_data_q <= bus.c_snp_data;
         end
         if (miss_latch) begin
            line_q   <= bus.cpu_addr[CADDR_W-1:2];
            vtag_q   <= bus.c_tag;
            victim_q <= bus.c_rd_data;
            sel_q    <= bus.cpu_addr[1:0];
            wr_q     <= bus.cpu_we;
            wdata_q  <= bus.cpu_wdata;
         end
         if ((state_q == ST_FILL) && bus.mem_rdy) fill_q <= bus.mem_rdata;
      end
   end

   always_comb begin
      state_d       = state_q;
      miss_latch    = 1'b0;
      bus.stall     = 1'b0;
      bus.c_addr    = line_q;
      bus.c_wr_data = '0;
      bus.c_wdirty  = 1'b0;
      bus.c_we      = 1'b0;
      bus.c_re      = 1'b0;
      bus.c_search  = 1'b0;
      bus.mem_re    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = line_q;
      bus.mem_wdata = victim_q;
      case (state_q)
         ST_IDLE: begin
            bus.c_addr = bus.cpu_addr[CADDR_W-1:2];
            bus.c_re   = cpu_req;
            if (cpu_req && bus.c_hit) begin
               if (bus.cpu_we) begin
                  bus.c_we      = 1'b1;
                  bus.c_wdirty  = 1'b1;
                  bus.c_wr_data = mux_merged;
               end
               if (snp_pend) state_d = ST_SNOOP;
            end else if (cpu_req) begin
               bus.stall = 1'b1;
               // A waiting snoop goes first; the miss is re-evaluated when IDLE returns.
               if (snp_pend) begin
                  state_d = ST_SNOOP;
               end else begin
                  miss_latch = 1'b1;
                  state_d    = bus.c_dirty ? ST_WB : ST_FILL;
               end
            end else if (snp_pend) begin
               state_d = ST_SNOOP;
            end
         end
         ST_SNOOP: begin
            bus.stall    = 1'b1;
            bus.c_search = 1'b1;
            state_d      = ST_IDLE;
         end
         ST_WB: begin
            bus.stall    = 1'b1;
            bus.mem_we   = 1'b1;
            bus.mem_addr = {vtag_q, line_q[IDX_W-1:0]};
            if (bus.mem_rdy) state_d = ST_FILL;
         end
         ST_FILL: begin
            bus.stall  = 1'b1;
            bus.mem_re = 1'b1;
            if (bus.mem_rdy) state_d = ST_INSTALL;
         end
         ST_INSTALL: begin
            bus.stall     = 1'b1;
            bus.c_we      = 1'b1;
            bus.c_wdirty  = wr_q;
            bus.c_wr_data = wr_q ? mux_merged : fill_q;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Scoreboard bench for dcache_ctrl with behavioural cache array and fixed-latency memory.
module tb_dcache_ctrl;
   import dcache_ctrl_pkg::*;

   typedef struct { logic wr; logic [63:0] line; } cpu_exp_t;
   typedef struct { logic we; logic [10:0] addr; logic [63:0] data; } mem_exp_t;
   typedef struct { logic hit; logic [63:0] data; } snp_exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   strobe_cnt = 0;
   int   strobe_at_ack = 0;
   int   mcnt = 0;

   cpu_exp_t cpu_q[$];
   mem_exp_t mem_q[$];
   snp_exp_t snp_q[$];

   logic [63:0] cdata  [64];
   logic [4:0]  ctag   [64];
   logic        cvalid [64];
   logic        cdirty [64];
   logic [63:0] mem    [2048];
   logic [5:0]  cidx, sidx;

   dcache_ctrl_if bus();

   dcache_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural cache array: combinational lookup, write on the clock edge.
   assign cidx            = bus.c_addr[5:0];
   assign sidx            = bus.c_snp_addr[5:0];
   assign bus.c_rd_data   = cdata[cidx];
   assign bus.c_tag       = ctag[cidx];
   assign bus.c_hit       = cvalid[cidx] && (ctag[cidx] == bus.c_addr[10:6]);
   assign bus.c_dirty     = cvalid[cidx] && cdirty[cidx];
   assign bus.c_snp_found = bus.c_search && cvalid[sidx] && (ctag[sidx] == bus.c_snp_addr[10:6]);
   assign bus.c_snp_data  = cdata[sidx];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) begin
            cvalid[i] <= 1'b0;
            cdirty[i] <= 1'b0;
            ctag[i]   <= '0;
            cdata[i]  <= '0;
         end
      end else if (bus.c_we) begin
         cvalid[cidx] <= 1'b1;
         cdirty[cidx] <= bus.c_wdirty;
         ctag[cidx]   <= bus.c_addr[10:6];
         cdata[cidx]  <= bus.c_wr_data;
      end
   end

   // Memory: completes each strobe on its third cycle with a one-cycle mem_rdy.
   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = '0;
      mem[11'h011] = 64'h4444_3333_2222_1111;
      mem[11'h211] = 64'hDDDD_CCCC_BBBB_AAAA;
      mem[11'h7FF] = 64'h7777_6666_5555_4444;
      bus.mem_rdy   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(posedge clk);
         #1;
         bus.mem_rdy = 1'b0;
         if ((bus.mem_re || bus.mem_we) && !rst) begin
            if (mcnt == 2) begin
               bus.mem_rdy = 1'b1;
               if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
               else            bus.mem_rdata = mem[bus.mem_addr];
               mcnt = 0;
            end else begin
               mcnt++;
            end
         end else begin
            mcnt = 0;
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_event(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event with no expectation queued", name);
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents a completion.
   always @(negedge clk) begin
      cpu_exp_t ce;
      mem_exp_t me;
      snp_exp_t se;
      if (!rst) begin
         if ((bus.cpu_re || bus.cpu_we) && !bus.stall) begin
            if (cpu_q.size() == 0) fail_event("cpu_done");
            else begin
               ce = cpu_q.pop_front();
               if (ce.wr) begin
                  check("wr_c_we", 64'(bus.c_we), 64'(1));
                  check("wr_c_wdirty", 64'(bus.c_wdirty), 64'(1));
                  check("wr_line", bus.c_wr_data, ce.line);
               end else begin
                  check("rd_data", 64'(bus.cpu_rdata), 64'(ce.line[15:0]));
               end
            end
         end
         if (bus.mem_rdy) begin
            if (mem_q.size() == 0) fail_event("mem_rdy");
            else begin
               me = mem_q.pop_front();
               check("mem_strobe", 64'({bus.mem_we, bus.mem_re}), me.we ? 64'(2) : 64'(1));
               check("mem_addr", 64'(bus.mem_addr), 64'(me.addr));
               if (me.we) check("mem_wdata", bus.mem_wdata, me.data);
            end
         end
         if (bus.snp_ack) begin
            if (snp_q.size() == 0) fail_event("snp_ack");
            else begin
               se = snp_q.pop_front();
               check("snp_hit", 64'(bus.snp_hit), 64'(se.hit));
               if (se.hit) check("snp_data", bus.snp_data, se.data);
            end
         end
         if (bus.mem_re || bus.mem_we) strobe_cnt++;
      end
   end

   task automatic cpu_op(input logic wr, input logic [12:0] addr, input logic [15:0] wd,
                         output int lat);
      bus.cpu_addr  = addr;
      bus.cpu_we    = wr;
      bus.cpu_re    = !wr;
      bus.cpu_wdata = wd;
      lat = -1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (!bus.stall) begin
            lat = n;
            break;
         end
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL cpu_timeout: addr %h still stalled after 200 cycles", addr);
      end
      @(posedge clk);
      #1;
      bus.cpu_re = 1'b0;
      bus.cpu_we = 1'b0;
   endtask

   task automatic snoop_op(input logic [10:0] addr, output int lat);
      bus.snp_req  = 1'b1;
      bus.snp_addr = addr;
      lat = -1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (bus.snp_ack) begin
            lat = n;
            strobe_at_ack = strobe_cnt;
            break;
         end
      end
      if (lat < 0) begin
         checks++;
         errors++;
         $display("FAIL snoop_timeout: addr %h no ack after 200 cycles", addr);
      end
      @(posedge clk);
      #1;
      bus.snp_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat_c, lat_s, strobe_base, rdy_seen;
      bus.cpu_addr  = '0;
      bus.cpu_re    = 1'b0;
      bus.cpu_we    = 1'b0;
      bus.cpu_wdata = '0;
      bus.snp_req   = 1'b0;
      bus.snp_addr  = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", 64'({bus.stall, bus.c_we, bus.c_re, bus.c_search, bus.snp_ack,
                                   bus.snp_hit, bus.mem_re, bus.mem_we}), 64'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Clean read miss, word 1 of line 0x011.
      mem_q.push_back('{we: 1'b0, addr: 11'h011, data: 64'h0});
      cpu_q.push_back('{wr: 1'b0, line: 64'h2222});
      cpu_op(1'b0, 13'h0045, 16'h0, lat_c);
      check("rd_miss_latency", 64'(lat_c), 64'(5));

      // Write hit, zero-latency, marks the line dirty.
      cpu_q.push_back('{wr: 1'b1, line: 64'h4444_3333_2222_BEEF});
      cpu_op(1'b1, 13'h0044, 16'hBEEF, lat_c);
      check("wr_hit_latency", 64'(lat_c), 64'(0));

      // Snoop wins over a simultaneous miss, then the dirty victim is written back.
      snp_q.push_back('{hit: 1'b1, data: 64'h4444_3333_2222_BEEF});
      mem_q.push_back('{we: 1'b1, addr: 11'h011, data: 64'h4444_3333_2222_BEEF});
      mem_q.push_back('{we: 1'b0, addr: 11'h211, data: 64'h0});
      cpu_q.push_back('{wr: 1'b0, line: 64'hAAAA});
      strobe_base = strobe_cnt;
      fork
         cpu_op(1'b0, 13'h0844, 16'h0, lat_c);
         snoop_op(11'h011, lat_s);
      join
      check("snoop_before_mem", 64'(strobe_at_ack - strobe_base), 64'(0));
      check("snoop_vs_miss_snp_latency", 64'(lat_s), 64'(2));
      check("dirty_miss_latency", 64'(lat_c), 64'(10));

      // Snoop on an empty index.
      snp_q.push_back('{hit: 1'b0, data: 64'h0});
      snoop_op(11'h3F0, lat_s);
      check("snoop_miss_latency", 64'(lat_s), 64'(2));

      // Read hit on word 3 of the freshly filled line.
      cpu_q.push_back('{wr: 1'b0, line: 64'hDDDD});
      cpu_op(1'b0, 13'h0847, 16'h0, lat_c);
      check("rd_hit_latency", 64'(lat_c), 64'(0));

      // Write miss: fill, merge word 2, install dirty.
      mem_q.push_back('{we: 1'b0, addr: 11'h400, data: 64'h0});
      cpu_q.push_back('{wr: 1'b1, line: 64'h0000_1234_0000_0000});
      cpu_op(1'b1, 13'h1002, 16'h1234, lat_c);
      check("wr_miss_latency", 64'(lat_c), 64'(5));

      // CPU hit completes in the same cycle a snoop arrives; snoop follows.
      cpu_q.push_back('{wr: 1'b0, line: 64'hBBBB});
      snp_q.push_back('{hit: 1'b1, data: 64'h0000_1234_0000_0000});
      fork
         cpu_op(1'b0, 13'h0845, 16'h0, lat_c);
         snoop_op(11'h400, lat_s);
      join
      check("hit_then_snoop_cpu_latency", 64'(lat_c), 64'(0));
      check("hit_then_snoop_snp_latency", 64'(lat_s), 64'(2));

      // Reset while the fill is outstanding.
      bus.cpu_addr = 13'h1FFC;
      bus.cpu_re   = 1'b1;
      lat_c = -1;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (bus.mem_re) begin
            lat_c = n;
            break;
         end
      end
      check("fill_started", 64'(lat_c >= 0), 64'(1));
      rst = 1'b1;
      bus.cpu_re = 1'b0;
      #1;
      check("rst_strobes", 64'({bus.mem_re, bus.mem_we, bus.stall, bus.c_we, bus.snp_ack}), 64'(0));
      check("rst_state", 64'(dut.state_q), 64'(ST_IDLE));
      rdy_seen = 0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (bus.mem_rdy || bus.mem_re || bus.mem_we) rdy_seen++;
      end
      check("no_mem_after_rst", 64'(rdy_seen), 64'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Same miss reissued after reset completes normally.
      mem_q.push_back('{we: 1'b0, addr: 11'h7FF, data: 64'h0});
      cpu_q.push_back('{wr: 1'b0, line: 64'h4444});
      cpu_op(1'b0, 13'h1FFC, 16'h0, lat_c);
      check("post_rst_miss_latency", 64'(lat_c), 64'(5));

      repeat (3) @(posedge clk);
      check("cpu_q_drained", 64'(cpu_q.size()), 64'(0));
      check("mem_q_drained", 64'(mem_q.size()), 64'(0));
      check("snp_q_drained", 64'(snp_q.size()), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
